// File: rtl/beam_error_gen.sv
// beam_error_gen: 4-channel complex beamformer output y = sum(w*x) and training error e = d - y,
// with x/w delayed to line up with e for the downstream weight update.
module beam_error_gen #(
  parameter int FRAC      = 15,
  parameter int TRAIN_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [17:0] x1I, x1Q, x2I, x2Q, x3I, x3Q, x4I, x4Q,
  input  logic [17:0] w1I, w1Q, w2I, w2Q, w3I, w3Q, w4I, w4Q,
  input  logic [17:0] dI, dQ,
  output logic        out_valid,
  output logic [17:0] yI, yQ,
  output logic [17:0] eI, eQ,
  output logic [17:0] xo1I, xo1Q, xo2I, xo2Q, xo3I, xo3Q, xo4I, xo4Q,
  output logic [17:0] wo1I, wo1Q, wo2I, wo2Q, wo3I, wo3Q, wo4I, wo4Q,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, TRAIN, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        tag_in;
  logic signed [17:0] x_i [4], x_q [4], w_i [4], w_q [4];
  logic signed [17:0] xi_p [3][4], xq_p [3][4], wi_p [3][4], wq_p [3][4];
  logic signed [17:0] di_p [3], dq_p [3];
  logic [2:0]         v_p, t_p;
  logic signed [35:0] m_ii [4], m_qq [4], m_iq [4], m_qi [4];
  logic signed [36:0] pi_c [4], pq_c [4], pi_r [4], pq_r [4];
  logic signed [37:0] si_r [2], sq_r [2];
  logic signed [38:0] acc_i, acc_q, ys_i, ys_q;
  logic signed [39:0] diff_i, diff_q;
  logic signed [17:0] xo_i [4], xo_q [4], wo_i [4], wo_q [4];
  assign x_i = '{x1I, x2I, x3I, x4I};
  assign x_q = '{x1Q, x2Q, x3Q, x4Q};
  assign w_i = '{w1I, w2I, w3I, w4I};
  assign w_q = '{w1Q, w2Q, w3Q, w4Q};
  assign {xo1I, xo2I, xo3I, xo4I} = {xo_i[0], xo_i[1], xo_i[2], xo_i[3]};
  assign {xo1Q, xo2Q, xo3Q, xo4Q} = {xo_q[0], xo_q[1], xo_q[2], xo_q[3]};
  assign {wo1I, wo2I, wo3I, wo4I} = {wo_i[0], wo_i[1], wo_i[2], wo_i[3]};
  assign {wo1Q, wo2Q, wo3Q, wo4Q} = {wo_q[0], wo_q[1], wo_q[2], wo_q[3]};
  // a start on the same cycle as a sample makes that sample training sample 0
  assign tag_in = in_valid && (start || state == TRAIN);
  function automatic logic [17:0] sat18(input logic signed [39:0] v);
    return (v[39:17] == {23{v[39]}}) ? v[17:0] : (v[39] ? 18'h20000 : 18'h1ffff);
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      state <= TRAIN;
      cnt   <= in_valid ? 16'd1 : 16'd0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == TRAIN && in_valid) begin
      if (cnt >= 16'(TRAIN_LEN - 1)) begin
        state <= DONE;
        cnt   <= '0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      m_ii[k] = 36'(wi_p[0][k]) * 36'(xi_p[0][k]);
      m_qq[k] = 36'(wq_p[0][k]) * 36'(xq_p[0][k]);
      m_iq[k] = 36'(wi_p[0][k]) * 36'(xq_p[0][k]);
      m_qi[k] = 36'(wq_p[0][k]) * 36'(xi_p[0][k]);
      pi_c[k] = {m_ii[k][35], m_ii[k]} - {m_qq[k][35], m_qq[k]};
      pq_c[k] = {m_iq[k][35], m_iq[k]} + {m_qi[k][35], m_qi[k]};
    end
    acc_i  = {si_r[0][37], si_r[0]} + {si_r[1][37], si_r[1]};
    acc_q  = {sq_r[0][37], sq_r[0]} + {sq_r[1][37], sq_r[1]};
    ys_i   = acc_i >>> FRAC;
    ys_q   = acc_q >>> FRAC;
    // error uses the unsaturated output so a clipped y does not distort e
    diff_i = {{22{di_p[2][17]}}, di_p[2]} - {ys_i[38], ys_i};
    diff_q = {{22{dq_p[2][17]}}, dq_p[2]} - {ys_q[38], ys_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_p       <= '0;
      t_p       <= '0;
      out_valid <= 1'b0;
      yI        <= '0;
      yQ        <= '0;
      eI        <= '0;
      eQ        <= '0;
      for (int s = 0; s < 3; s++) begin
        di_p[s] <= '0;
        dq_p[s] <= '0;
        for (int k = 0; k < 4; k++) begin
          xi_p[s][k] <= '0;
          xq_p[s][k] <= '0;
          wi_p[s][k] <= '0;
          wq_p[s][k] <= '0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        pi_r[k] <= '0;
        pq_r[k] <= '0;
        xo_i[k] <= '0;
        xo_q[k] <= '0;
        wo_i[k] <= '0;
        wo_q[k] <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        si_r[k] <= '0;
        sq_r[k] <= '0;
      end
    end else begin
      v_p     <= {v_p[1:0], in_valid};
      t_p     <= {t_p[1:0], tag_in};
      di_p[0] <= dI;
      dq_p[0] <= dQ;
      for (int s = 1; s < 3; s++) begin
        di_p[s] <= di_p[s-1];
        dq_p[s] <= dq_p[s-1];
      end
      for (int k = 0; k < 4; k++) begin
        xi_p[0][k] <= x_i[k];
        xq_p[0][k] <= x_q[k];
        wi_p[0][k] <= w_i[k];
        wq_p[0][k] <= w_q[k];
        for (int s = 1; s < 3; s++) begin
          xi_p[s][k] <= xi_p[s-1][k];
          xq_p[s][k] <= xq_p[s-1][k];
          wi_p[s][k] <= wi_p[s-1][k];
          wq_p[s][k] <= wq_p[s-1][k];
        end
        pi_r[k] <= pi_c[k];
        pq_r[k] <= pq_c[k];
      end
      si_r[0]   <= {pi_r[0][36], pi_r[0]} + {pi_r[1][36], pi_r[1]};
      si_r[1]   <= {pi_r[2][36], pi_r[2]} + {pi_r[3][36], pi_r[3]};
      sq_r[0]   <= {pq_r[0][36], pq_r[0]} + {pq_r[1][36], pq_r[1]};
      sq_r[1]   <= {pq_r[2][36], pq_r[2]} + {pq_r[3][36], pq_r[3]};
      out_valid <= v_p[2];
      if (v_p[2]) begin
        yI <= sat18({ys_i[38], ys_i});
        yQ <= sat18({ys_q[38], ys_q});
        eI <= t_p[2] ? sat18(diff_i) : 18'd0;
        eQ <= t_p[2] ? sat18(diff_q) : 18'd0;
        for (int k = 0; k < 4; k++) begin
          xo_i[k] <= xi_p[2][k];
          xo_q[k] <= xq_p[2][k];
          wo_i[k] <= wi_p[2][k];
          wo_q[k] <= wq_p[2][k];
        end
      end
    end
  end
endmodule

// File: tb/tb_beam_error_gen.sv
// tb_beam_error_gen: directed vector table plus multi-cycle training/reset sequences for beam_error_gen.
module tb_beam_error_gen;
  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic signed [17:0] xi [4], xq [4], wi [4], wq [4];
  logic signed [17:0] di, dq;
  logic out_valid, busy, done;
  logic signed [17:0] yI, yQ, eI, eQ;
  logic signed [17:0] xo1I, xo1Q, xo2I, xo2Q, xo3I, xo3Q, xo4I, xo4Q;
  logic signed [17:0] wo1I, wo1Q, wo2I, wo2Q, wo3I, wo3Q, wo4I, wo4Q;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  beam_error_gen #(.FRAC(15), .TRAIN_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .x1I(xi[0]), .x1Q(xq[0]), .x2I(xi[1]), .x2Q(xq[1]),
    .x3I(xi[2]), .x3Q(xq[2]), .x4I(xi[3]), .x4Q(xq[3]),
    .w1I(wi[0]), .w1Q(wq[0]), .w2I(wi[1]), .w2Q(wq[1]),
    .w3I(wi[2]), .w3Q(wq[2]), .w4I(wi[3]), .w4Q(wq[3]),
    .dI(di), .dQ(dq), .out_valid(out_valid),
    .yI(yI), .yQ(yQ), .eI(eI), .eQ(eQ),
    .xo1I(xo1I), .xo1Q(xo1Q), .xo2I(xo2I), .xo2Q(xo2Q),
    .xo3I(xo3I), .xo3Q(xo3Q), .xo4I(xo4I), .xo4Q(xo4Q),
    .wo1I(wo1I), .wo1Q(wo1Q), .wo2I(wo2I), .wo2Q(wo2Q),
    .wo3I(wo3I), .wo3Q(wo3Q), .wo4I(wo4I), .wo4Q(wo4Q),
    .busy(busy), .done(done)
  );
  typedef struct {
    bit [3:0] ch;
    int xi, xq, wi, wq, di, dq;
    bit tr;
    int yi, yq, ei, eq;
  } vec_t;
  vec_t vt [9];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic set_in(input bit [3:0] ch, input int x_i, x_q, w_i, w_q, d_i, d_q);
    for (int k = 0; k < 4; k++) begin
      xi[k] = ch[k] ? 18'(x_i) : 18'd0;
      xq[k] = ch[k] ? 18'(x_q) : 18'd0;
      wi[k] = ch[k] ? 18'(w_i) : 18'd0;
      wq[k] = ch[k] ? 18'(w_q) : 18'd0;
    end
    di = 18'(d_i);
    dq = 18'(d_q);
  endtask
  task automatic apply(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    set_in(v.ch, v.xi, v.xq, v.wi, v.wq, v.di, v.dq);
    in_valid = 1'b1;
    start = v.tr;
    @(negedge clk);
    set_in(4'b0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 4);
    chk({nm, " yI"}, yI, v.yi);
    chk({nm, " yQ"}, yQ, v.yq);
    chk({nm, " eI"}, eI, v.ei);
    chk({nm, " eQ"}, eQ, v.eq);
    chk({nm, " xo1I"}, xo1I, v.xi);
    chk({nm, " wo1Q"}, wo1Q, v.wq);
    chk({nm, " wo4I"}, wo4I, v.ch[3] ? v.wi : 0);
    @(negedge clk);
    chk({nm, " valid pulse"}, int'(out_valid), 0);
    chk({nm, " hold yI"}, yI, v.yi);
  endtask
  task automatic pulse(input bit v, input bit s);
    @(negedge clk);
    in_valid = v;
    start = s;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask
  initial begin
    int e_got [12];
    int n_out;
    vec_t t1;
    vt[0] = '{4'b0001, 1000, 0, 32768, 0, 3000, 0, 1'b0, 1000, 0, 0, 0};
    vt[1] = '{4'b0001, -1, 0, 1, 0, 0, 0, 1'b0, -1, 0, 0, 0};
    vt[2] = '{4'b0001, 1000, 0, 32768, 0, 3000, 0, 1'b1, 1000, 0, 2000, 0};
    vt[3] = '{4'b0001, 1000, 500, 0, 32768, 0, 0, 1'b1, -500, 1000, 500, -1000};
    vt[4] = '{4'b1111, 131071, 0, 131071, 0, -131072, 0, 1'b1, 131071, 0, -131072, 0};
    vt[5] = '{4'b0001, -1, 0, 1, 0, 5, 0, 1'b1, -1, 0, 6, 0};
    vt[6] = '{4'b0011, 2000, -2000, 16384, 16384, -1000, 7, 1'b1, 4000, 0, -5000, 7};
    vt[7] = '{4'b1111, -131072, 0, 131071, 0, 131071, 0, 1'b1, -131072, 0, 131071, 0};
    vt[8] = '{4'b0001, 100000, 0, 32768, 0, -100000, 0, 1'b1, 100000, 0, -131072, 0};
    t1 = vt[2];
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    set_in(4'b0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset yI", yI, 0);
    chk("reset eI", eI, 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    for (int i = 0; i < 9; i++) apply(vt[i], $sformatf("vec%0d", i));
    // run of TRAIN_LEN=4: start alone, then 6 back-to-back samples
    pulse(1'b0, 1'b1);
    idle();
    chk("run busy after start", int'(busy), 1);
    n_out = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && n_out < 12) begin
        e_got[n_out] = eI;
        n_out++;
      end
      if (c == 3) chk("run done after 3", int'(done), 0);
      if (c == 4) begin
        chk("run done after 4", int'(done), 1);
        chk("run busy after 4", int'(busy), 0);
      end
      if (c < 6) set_in(4'b0001, 1000, 0, 32768, 0, 3000, 0);
      else set_in(4'b0, 0, 0, 0, 0, 0, 0);
      in_valid = (c < 6);
    end
    chk("run out count", n_out, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("run e%0d", i), e_got[i], i < 4 ? 2000 : 0);
    // start in DONE together with a valid sample
    apply(t1, "done_start");
    chk("done_start busy", int'(busy), 1);
    chk("done_start done", int'(done), 0);
    // start on the final sample restarts the count
    set_in(4'b0001, 1000, 0, 32768, 0, 3000, 0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    idle();
    chk("final_start busy", int'(busy), 1);
    chk("final_start done", int'(done), 0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    idle();
    chk("restart done after 3", int'(done), 0);
    pulse(1'b1, 1'b0);
    idle();
    chk("restart done after 4", int'(done), 1);
    repeat (6) idle();
    // reset with three samples in flight
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4'b0, 0, 0, 0, 0, 0, 0);
    n_out = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) n_out++;
    end
    chk("rst flight pulses", n_out, 0);
    chk("rst yI", yI, 0);
    chk("rst eI", eI, 0);
    chk("rst xo1I", xo1I, 0);
    chk("rst wo1I", wo1I, 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
